// File: rtl/ip_tx_stream_arbiter_if.sv
// Valid/ready byte-stream bundle, LANES parallel lanes of DATA_WIDTH each.
// Latency: none (wires only).
// Backpressure: tready flows from slave to master, per lane.
// Ports (modports):
//   master : drives tdata/tvalid/tlast, samples tready
//   slave  : samples tdata/tvalid/tlast, drives tready
interface ip_tx_stream_arbiter_if #(
  parameter int LANES      = 1,
  parameter int DATA_WIDTH = 8
);
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tlast;
  logic [LANES-1:0]            tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ip_tx_stream_arbiter.sv
// Packet-granular round-robin arbiter with a stall watchdog onto one TX byte path.
// Latency: one bubble cycle per packet for arbitration, then combinational passthrough.
// Backpressure: m.tready is forwarded to the granted port only; flushing ports are drained.
// Ports:
//   clk, reset_n     clock and asynchronous active-low reset
//   s (slave)        N_PORTS producer lanes, lane i at tdata[i*DATA_WIDTH +: DATA_WIDTH]
//   m (master)       single arbitrated lane towards the TX FIFO
//   m_tuser          1 on the terminating beat of an aborted packet
//   grant            one-hot current owner, zero while idle
//   abort            one-cycle pulse when the watchdog fires
module ip_tx_stream_arbiter #(
  parameter int N_PORTS    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ip_tx_stream_arbiter_if.slave  s,
  ip_tx_stream_arbiter_if.master m,
  output logic                   m_tuser,
  output logic [N_PORTS-1:0]     grant,
  output logic                   abort
);

  localparam int PW = $clog2(N_PORTS);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_ABORT} state_t;

  state_t               state, state_nxt;
  logic [PW-1:0]        ptr, ptr_nxt;
  logic [PW-1:0]        gidx, gidx_nxt;
  logic [N_PORTS-1:0]   flush, flush_nxt;
  logic [N_PORTS-1:0]   grant_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [N_PORTS-1:0]   cand;
  logic                 pick_vld;
  logic [PW-1:0]        pick_idx;
  logic [PW-1:0]        rr_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      ptr   <= PW'(N_PORTS - 1);
      gidx  <= '0;
      flush <= '0;
      grant <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gidx  <= gidx_nxt;
      flush <= flush_nxt;
      grant <= grant_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    flush_nxt = flush;
    grant_nxt = grant;
    cnt_nxt   = cnt;
    s.tready  = '0;
    m.tdata   = '0;
    m.tvalid  = 1'b0;
    m.tlast   = 1'b0;
    m_tuser   = 1'b0;
    abort     = 1'b0;

    // Round-robin search starting one past the last owner.
    cand     = s.tvalid & ~flush;
    pick_vld = 1'b0;
    pick_idx = '0;
    rr_sel   = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      rr_sel = PW'((int'(ptr) + k) % N_PORTS);
      if (!pick_vld && cand[rr_sel]) begin
        pick_vld = 1'b1;
        pick_idx = rr_sel;
      end
    end

    // Drain the remainder of an aborted packet; the owner is never drained,
    // which keeps it stalled while the abort beat is still outstanding.
    for (int i = 0; i < N_PORTS; i++) begin
      if (flush[i] && !grant[i]) begin
        s.tready[i] = 1'b1;
        if (s.tvalid[i] && s.tlast[i]) flush_nxt[i] = 1'b0;
      end
    end

    unique case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_nxt           = '0;
          grant_nxt[pick_idx] = 1'b1;
          gidx_nxt            = pick_idx;
          cnt_nxt             = '0;
          state_nxt           = ST_PASS;
        end
      end

      ST_PASS: begin
        m.tdata        = s.tdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
        m.tvalid       = s.tvalid[gidx];
        m.tlast        = s.tlast[gidx];
        s.tready[gidx] = m.tready;
        if (s.tvalid[gidx] && m.tready) begin
          cnt_nxt = '0;
          if (s.tlast[gidx]) begin
            ptr_nxt   = gidx;
            grant_nxt = '0;
            state_nxt = ST_IDLE;
          end
        end else if (!s.tvalid[gidx] && TIMEOUT != 0) begin
          // Only producer silence counts; a downstream stall keeps valid high.
          if (cnt == WD_LAST) begin
            abort           = 1'b1;
            flush_nxt[gidx] = 1'b1;
            state_nxt       = ST_ABORT;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end

      ST_ABORT: begin
        m.tvalid = 1'b1;
        m.tlast  = 1'b1;
        m_tuser  = 1'b1;
        if (m.tready) begin
          ptr_nxt   = gidx;
          grant_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ip_tx_stream_arbiter.sv
`timescale 1ns/1ps
module tb_ip_tx_stream_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       m_tuser;
  logic [1:0] grant;
  logic       abort;

  ip_tx_stream_arbiter_if #(.LANES(2), .DATA_WIDTH(8)) s_if ();
  ip_tx_stream_arbiter_if #(.LANES(1), .DATA_WIDTH(8)) m_if ();

  ip_tx_stream_arbiter #(.N_PORTS(2), .DATA_WIDTH(8), .TIMEOUT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (s_if),
    .m       (m_if),
    .m_tuser (m_tuser),
    .grant   (grant),
    .abort   (abort)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Source beats {last, data}; scoreboard beats {tuser, tlast, data}.
  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [9:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present();
    s_if.tvalid = 2'b00;
    s_if.tlast  = 2'b00;
    s_if.tdata  = 16'h0000;
    if (src0.size() > 0) begin
      s_if.tvalid[0]   = 1'b1;
      s_if.tlast[0]    = src0[0][8];
      s_if.tdata[7:0]  = src0[0][7:0];
    end
    if (src1.size() > 0) begin
      s_if.tvalid[1]   = 1'b1;
      s_if.tlast[1]    = src1[0][8];
      s_if.tdata[15:8] = src1[0][7:0];
    end
  endtask

  task automatic push(input int port, input logic [7:0] d, input logic last, input logic expect_out);
    if (port == 0) src0.push_back({last, d});
    else           src1.push_back({last, d});
    if (expect_out) sb.push_back({1'b0, last, d});
  endtask

  // Checks any output beat of the current cycle, advances one clock, retires consumed source beats.
  task automatic cyc();
    logic [1:0] fire;
    logic [9:0] e;
    if (m_if.tvalid[0] && m_if.tready[0]) begin
      check("beat_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_beat", {m_tuser, m_if.tlast[0], m_if.tdata}, e);
      end
    end
    fire = s_if.tvalid & s_if.tready;
    @(posedge clk);
    #1;
    if (fire[0] && src0.size() > 0) void'(src0.pop_front());
    if (fire[1] && src1.size() > 0) void'(src1.pop_front());
    present();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    src0.delete();
    src1.delete();
    sb.delete();
    present();
    #1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] g2 [12];
    int guard;
    g2 = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
           2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};

    reset_n        = 1'b0;
    m_if.tready[0] = 1'b1;
    present();
    #1;
    check("rst_grant",   grant, 2'b00);
    check("rst_mvalid",  m_if.tvalid, 1'b0);
    check("rst_mtuser",  m_tuser, 1'b0);
    check("rst_abort",   abort, 1'b0);
    check("rst_sready",  s_if.tready, 2'b00);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;

    // Test 1: single producer, 3-beat packet.
    push(0, 8'hAA, 1'b0, 1'b1);
    push(0, 8'hBB, 1'b0, 1'b1);
    push(0, 8'hCC, 1'b1, 1'b1);
    present();
    #1;
    check("t1_idle_grant",  grant, 2'b00);
    check("t1_idle_mvalid", m_if.tvalid, 1'b0);
    cyc();
    check("t1_grant", grant, 2'b01);
    check("t1_d0", {m_if.tvalid[0], m_if.tlast[0], m_if.tdata}, {1'b1, 1'b0, 8'hAA});
    cyc();
    check("t1_d1", {m_if.tvalid[0], m_if.tlast[0], m_if.tdata}, {1'b1, 1'b0, 8'hBB});
    cyc();
    check("t1_d2", {m_if.tvalid[0], m_if.tlast[0], m_if.tdata}, {1'b1, 1'b1, 8'hCC});
    cyc();
    check("t1_release", grant, 2'b00);

    // Test 2: both ports request simultaneously from reset.
    do_reset();
    push(0, 8'h10, 1'b0, 1'b1);
    push(0, 8'h11, 1'b1, 1'b1);
    push(1, 8'h20, 1'b0, 1'b1);
    push(1, 8'h21, 1'b1, 1'b1);
    push(0, 8'h30, 1'b0, 1'b1);
    push(0, 8'h31, 1'b1, 1'b1);
    push(1, 8'h40, 1'b0, 1'b1);
    push(1, 8'h41, 1'b1, 1'b1);
    present();
    #1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      check($sformatf("t2_grant_%0d", k), grant, g2[k]);
    end
    check("t2_drained", sb.size(), 0);

    // Test 3: downstream toggles ready during a P1 packet.
    push(1, 8'h50, 1'b0, 1'b1);
    push(1, 8'h51, 1'b0, 1'b1);
    push(1, 8'h52, 1'b1, 1'b1);
    present();
    #1;
    cyc();
    check("t3_grant", grant, 2'b10);
    for (int k = 0; k < 5; k++) begin
      m_if.tready[0] = ((k % 2) == 0);
      #1;
      check($sformatf("t3_sready1_%0d", k), s_if.tready[1], 32'((k % 2) == 0));
      check($sformatf("t3_sready0_%0d", k), s_if.tready[0], 1'b0);
      check($sformatf("t3_abort_%0d", k),   abort, 1'b0);
      cyc();
    end
    m_if.tready[0] = 1'b1;
    #1;
    check("t3_release", grant, 2'b00);

    // Test 4: P0 goes silent mid-packet, watchdog aborts.
    push(0, 8'h60, 1'b0, 1'b1);
    sb.push_back({1'b1, 1'b1, 8'h00});
    present();
    #1;
    cyc();
    check("t4_grant", grant, 2'b01);
    cyc();
    check("t4_mvalid_gap", m_if.tvalid, 1'b0);
    for (int w = 1; w <= 8; w++) begin
      check($sformatf("t4_abort_w%0d", w), abort, 32'(w == 8));
      if (w < 8) cyc();
    end
    cyc();
    check("t4_abort_beat", {m_if.tvalid[0], m_if.tlast[0], m_tuser, m_if.tdata},
          {1'b1, 1'b1, 1'b1, 8'h00});
    check("t4_abort_cleared", abort, 1'b0);
    check("t4_sready0", s_if.tready[0], 1'b0);
    cyc();
    check("t4_release", grant, 2'b00);

    // Test 5: aborted port flushes its tail while P1 is served.
    push(0, 8'h70, 1'b0, 1'b0);
    push(0, 8'h71, 1'b0, 1'b0);
    push(0, 8'h72, 1'b0, 1'b0);
    push(0, 8'h73, 1'b1, 1'b0);
    push(1, 8'h80, 1'b0, 1'b1);
    push(1, 8'h81, 1'b1, 1'b1);
    present();
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t5_flush_rdy_%0d", k), s_if.tready[0], 1'b1);
      cyc();
      if (k == 0) check("t5_grant_p1", grant, 2'b10);
    end
    check("t5_idle", grant, 2'b00);
    check("t5_flush_done", s_if.tready[0], 1'b0);
    push(0, 8'h90, 1'b1, 1'b1);
    present();
    #1;
    cyc();
    check("t5_rejoin", grant, 2'b01);
    cyc();
    check("t5_release", grant, 2'b00);

    // Test 6: reset asserted mid-packet.
    push(1, 8'hA0, 1'b0, 1'b1);
    push(1, 8'hA1, 1'b0, 1'b0);
    push(1, 8'hA2, 1'b1, 1'b0);
    present();
    #1;
    cyc();
    check("t6_grant", grant, 2'b10);
    cyc();
    reset_n = 1'b0;
    #1;
    check("t6_rst_grant",  grant, 2'b00);
    check("t6_rst_mvalid", m_if.tvalid, 1'b0);
    check("t6_rst_sready", s_if.tready, 2'b00);
    check("t6_rst_mdata",  m_if.tdata, 8'h00);
    src0.delete();
    src1.delete();
    present();
    #1;
    reset_n = 1'b1;
    #1;
    push(0, 8'hB0, 1'b1, 1'b1);
    push(1, 8'hC0, 1'b1, 1'b1);
    present();
    #1;
    cyc();
    check("t6_first_p0", grant, 2'b01);
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      cyc();
      guard++;
    end
    check("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
